// File: rtl/dual_dmem_responder.sv
// Shared data-memory responder for two cores: posted store queue, forwarded loads.
// Ports: clk, rst (async low); per core memwriteM/aluoutM/writedataM in, readdataM out; stall, qcount out.
module dual_dmem_responder #(
    parameter int DEPTH  = 64,
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_memwriteM,
    input  logic [31:0]               a_aluoutM,
    input  logic [31:0]               a_writedataM,
    output logic [31:0]               a_readdataM,
    input  logic                      b_memwriteM,
    input  logic [31:0]               b_aluoutM,
    input  logic [31:0]               b_writedataM,
    output logic [31:0]               b_readdataM,
    output logic                      stall,
    output logic [$clog2(QDEPTH):0]   qcount
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_mem   [DEPTH];
    logic [IW-1:0] r_qidx  [QDEPTH];
    logic [31:0]   r_qdata [QDEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [IW-1:0] w_a_idx;
    logic [IW-1:0] w_b_idx;
    logic          w_push_a;
    logic          w_push_b;
    logic          w_drain;
    logic [PW-1:0] w_tail_b;
    logic [CW-1:0] w_count_nxt;
    logic          w_unused;

    assign w_a_idx = a_aluoutM[IW+1:2];
    assign w_b_idx = b_aluoutM[IW+1:2];

    // Byte offset and address bits above the RAM are don't-care.
    assign w_unused = ^{a_aluoutM[31:IW+2], a_aluoutM[1:0],
                        b_aluoutM[31:IW+2], b_aluoutM[1:0]};

    // Hold both cores unless two pushes are guaranteed to fit.
    assign stall    = r_count > CW'(QDEPTH - 2);
    assign qcount   = r_count;

    assign w_push_a = a_memwriteM && !stall;
    assign w_push_b = b_memwriteM && !stall;
    assign w_drain  = r_count != '0;

    // B is younger: it lands one slot past A when both push.
    assign w_tail_b = r_tail + PW'(w_push_a);

    assign w_count_nxt = r_count
                       + CW'(w_push_a)
                       + CW'(w_push_b)
                       - CW'(w_drain);

    // Walk from oldest to youngest so the youngest match wins.
    function automatic logic [31:0] f_load(input logic [IW-1:0] idx);
        logic [31:0]   v;
        logic [PW-1:0] p;
        v = r_mem[idx];
        for (int k = 0; k < QDEPTH; k++) begin
            p = r_head + PW'(k);
            if ((CW'(k) < r_count) && (r_qidx[p] == idx)) begin
                v = r_qdata[p];
            end
        end
        return v;
    endfunction

    always_comb begin
        a_readdataM = f_load(w_a_idx);
        b_readdataM = f_load(w_b_idx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            for (int i = 0; i < QDEPTH; i++) begin
                r_qidx[i]  <= '0;
                r_qdata[i] <= '0;
            end
        end else begin
            if (w_drain) begin
                r_mem[r_qidx[r_head]] <= r_qdata[r_head];
                r_head                <= r_head + PW'(1);
            end
            if (w_push_a) begin
                r_qidx[r_tail]  <= w_a_idx;
                r_qdata[r_tail] <= a_writedataM;
            end
            if (w_push_b) begin
                r_qidx[w_tail_b]  <= w_b_idx;
                r_qdata[w_tail_b] <= b_writedataM;
            end
            r_tail  <= r_tail + PW'(w_push_a) + PW'(w_push_b);
            r_count <= w_count_nxt;
        end
    end
endmodule

// File: tb/tb_dual_dmem_responder.sv
// Scoreboard bench for dual_dmem_responder.
// Expected values come from a queue-based reference model.
module tb_dual_dmem_responder;
    localparam int DEPTH  = 64;
    localparam int QDEPTH = 4;

    logic        clk;
    logic        rst;
    logic        a_memwriteM;
    logic [31:0] a_aluoutM;
    logic [31:0] a_writedataM;
    logic [31:0] a_readdataM;
    logic        b_memwriteM;
    logic [31:0] b_aluoutM;
    logic [31:0] b_writedataM;
    logic [31:0] b_readdataM;
    logic        stall;
    logic [2:0]  qcount;

    dual_dmem_responder #(.DEPTH(DEPTH), .QDEPTH(QDEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_memwriteM  (a_memwriteM),
        .a_aluoutM    (a_aluoutM),
        .a_writedataM (a_writedataM),
        .a_readdataM  (a_readdataM),
        .b_memwriteM  (b_memwriteM),
        .b_aluoutM    (b_aluoutM),
        .b_writedataM (b_writedataM),
        .b_readdataM  (b_readdataM),
        .stall        (stall),
        .qcount       (qcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    string       sb_tag[$];
    logic [31:0] sb_val[$];

    logic [31:0] m_mem [DEPTH];
    logic [5:0]  m_qi[$];
    logic [31:0] m_qd[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_qi.delete();
        m_qd.delete();
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        logic [5:0]  idx;
        logic [31:0] v;
        idx = a[7:2];
        v   = m_mem[idx];
        foreach (m_qi[i]) if (m_qi[i] == idx) v = m_qd[i];
        return v;
    endfunction

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic sb_drain();
        string       tag;
        logic [31:0] exp;
        logic [31:0] got;
        while (sb_tag.size() > 0) begin
            tag = sb_tag.pop_front();
            exp = sb_val.pop_front();
            case (tag)
                "stall":  got = {31'b0, stall};
                "qcount": got = {29'b0, qcount};
                "a_rd":   got = a_readdataM;
                "b_rd":   got = b_readdataM;
                default:  got = 'x;
            endcase
            check(tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cyc(input logic aw, input logic [31:0] aa,
                       input logic [31:0] ad, input logic bw,
                       input logic [31:0] ba, input logic [31:0] bd);
        logic es;
        a_memwriteM  = aw;
        a_aluoutM    = aa;
        a_writedataM = ad;
        b_memwriteM  = bw;
        b_aluoutM    = ba;
        b_writedataM = bd;
        es = (QDEPTH - m_qi.size()) < 2;
        sb_push("stall", {31'b0, es});
        sb_push("qcount", 32'(m_qi.size()));
        sb_push("a_rd", mread(aa));
        sb_push("b_rd", mread(ba));
        @(negedge clk);
        sb_drain();
        @(posedge clk);
        if (m_qi.size() != 0) begin
            m_mem[m_qi[0]] = m_qd[0];
            void'(m_qi.pop_front());
            void'(m_qd.pop_front());
        end
        if (!es && aw) begin
            m_qi.push_back(aa[7:2]);
            m_qd.push_back(ad);
        end
        if (!es && bw) begin
            m_qi.push_back(ba[7:2]);
            m_qd.push_back(bd);
        end
        #1;
    endtask

    task automatic idle(input logic [31:0] aa, input logic [31:0] ba, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, aa, '0, 1'b0, ba, '0);
    endtask

    initial begin
        rst          = 1'b0;
        a_memwriteM  = 1'b0;
        a_aluoutM    = '0;
        a_writedataM = '0;
        b_memwriteM  = 1'b0;
        b_aluoutM    = 32'h10;
        b_writedataM = '0;
        m_reset();
        #1;
        check("rst_qcount", {29'b0, qcount}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_a_rd", a_readdataM, 32'h0);
        check("rst_b_rd", b_readdataM, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // single store, forwarded then from RAM
        cyc(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h10, '0);
        idle(32'h10, 32'h10, 3);

        // same-cycle conflict, B wins
        cyc(1'b1, 32'h20, 32'h11111111, 1'b1, 32'h20, 32'h22222222);
        idle(32'h20, 32'h20, 4);

        // youngest forwarding
        for (int v = 1; v <= 3; v++) cyc(1'b1, 32'h0, 32'(v), 1'b0, 32'h0, '0);
        idle(32'h0, 32'h0, 4);

        // backpressure: both cores store every cycle
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'h40 + 32'(8 * i), 32'hA0000000 + 32'(i),
                1'b1, 32'h44 + 32'(8 * i), 32'hB0000000 + 32'(i));
        idle(32'h40, 32'h44, 6);
        for (int i = 0; i < 8; i++)
            idle(32'h40 + 32'(8 * i), 32'h44 + 32'(8 * i), 1);

        // pointer wrap with single stores
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0, 32'(4 * i), '0);
        idle(32'h0, 32'h4, 5);
        for (int i = 0; i < 5; i++)
            idle(32'(8 * i), 32'(8 * i + 4), 1);

        // reset while the queue is draining
        cyc(1'b1, 32'h30, 32'h00005555, 1'b1, 32'h34, 32'h00006666);
        a_memwriteM = 1'b0;
        b_memwriteM = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mrst_qcount", {29'b0, qcount}, 32'h0);
        check("mrst_stall", {31'b0, stall}, 32'h0);
        check("mrst_a_rd", a_readdataM, 32'h0);
        check("mrst_b_rd", b_readdataM, 32'h0);
        a_aluoutM = 32'h10;
        b_aluoutM = 32'h20;
        #1;
        check("mrst_a_rd2", a_readdataM, 32'h0);
        check("mrst_b_rd2", b_readdataM, 32'h0);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(32'h30, 32'h34, 2);
        idle(32'h10, 32'h20, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
